axis_master_buf: RTL and testbench

Parametrised AXI-Stream master with a backend-side FIFO, carrying per-beat keep, last and user fields from the backend. It replaces the single-beat axis master, which had no buffering, fixed widths, an idle cycle per beat and a forced tlast. The block sits between a backend producer (valid/ready) and the AXI-Stream fabric. It sustains one beat per clock and can hold back whole packets until they are fully buffered.

---
 rtl/axis_master_buf_if.sv | 37 +++
 rtl/axis_master_buf.sv | 155 +++++++++++++++
 tb/tb_axis_master_buf.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_master_buf_if.sv
// axis_master_buf_if: groups the backend (valid/ready) and AXI-Stream signals for axis_master_buf.
// Latency: none; this is a plain signal bundle.
// Backpressure: carried by bk_ready (to the backend) and axis_tready (from the sink).
// Ports: master = buffer side (bk_* in, axis_t* out, axis_tready in); slave = the opposite view.
interface axis_master_buf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
);
    logic [DATA_WIDTH-1:0]   bk_data;
    logic [DATA_WIDTH/8-1:0] bk_keep;
    logic [USER_WIDTH-1:0]   bk_user;
    logic                    bk_last;
    logic                    bk_valid;
    logic                    bk_ready;

    logic                    axis_tvalid;
    logic [DATA_WIDTH-1:0]   axis_tdata;
    logic [DATA_WIDTH/8-1:0] axis_tkeep;
    logic [DATA_WIDTH/8-1:0] axis_tstrb;
    logic                    axis_tlast;
    logic [USER_WIDTH-1:0]   axis_tuser;
    logic                    axis_tready;

    modport master (
        input  bk_data, bk_keep, bk_user, bk_last, bk_valid,
        output bk_ready,
        output axis_tvalid, axis_tdata, axis_tkeep, axis_tstrb, axis_tlast, axis_tuser,
        input  axis_tready
    );

    modport slave (
        output bk_data, bk_keep, bk_user, bk_last, bk_valid,
        input  bk_ready,
        input  axis_tvalid, axis_tdata, axis_tkeep, axis_tstrb, axis_tlast, axis_tuser,
        output axis_tready
    );
endinterface

// File: rtl/axis_master_buf.sv
// axis_master_buf: backend valid/ready beats into a DEPTH-entry FIFO, presented as an AXI-Stream master.
// Latency: tvalid one cycle after the write (cut-through); PKT_MODE=1 holds a packet until its tlast is stored or the FIFO is full.
// Backpressure: bk_ready low while DEPTH entries are stored; head payload held stable while axis_tready is low.
// Ports: axi_aclk, axi_aresetn (async, active-low), bus (master modport), level (entries stored), pkt_cnt (tlast beats sent).
module axis_master_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int PKT_MODE   = 0
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    axis_master_buf_if.master      bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KW-1:0]         keep;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } entry_t;

    typedef enum logic {
        S_GATE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    entry_t         mem [DEPTH];
    entry_t         head;
    entry_t         wr_entry;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  pkts;
    state_t         state;
    state_t         state_nxt;
    logic           tvalid_c;
    logic           not_empty;
    logic           full;
    logic           wr_en;
    logic           rd_en;

    assign not_empty = (level != '0);
    assign full      = (level == FULL_LVL);

    // No pass-through when full: a same-cycle read does not open a write slot.
    assign bus.bk_ready = !full;
    assign wr_en        = bus.bk_valid && !full;
    assign rd_en        = tvalid_c && bus.axis_tready;

    assign wr_entry = '{data: bus.bk_data, keep: bus.bk_keep, user: bus.bk_user, last: bus.bk_last};
    assign head     = mem[rd_ptr];

    assign bus.axis_tvalid = tvalid_c;
    assign bus.axis_tdata  = head.data;
    assign bus.axis_tkeep  = head.keep;
    assign bus.axis_tstrb  = head.keep;
    assign bus.axis_tuser  = head.user;
    assign bus.axis_tlast  = head.last;

    // Storage and pointers; pointers are exactly AW bits so rollover is free.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter; simultaneous write and read leave it unchanged.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            level <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Complete packets held in the FIFO: counted in on a stored tlast, out on a sent tlast.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkts <= '0;
        end else begin
            case ({wr_en && bus.bk_last, rd_en && head.last})
                2'b10:   pkts <= pkts + 1'b1;
                2'b01:   pkts <= pkts - 1'b1;
                default: pkts <= pkts;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_cnt <= '0;
        end else if (rd_en && head.last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= S_GATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate terms only ever clear through a read (a full FIFO cannot be written,
    // a stored packet cannot leave), so tvalid never drops without a handshake.
    // Releasing on full keeps packets longer than DEPTH from deadlocking.
    always_comb begin
        state_nxt = state;
        tvalid_c  = 1'b0;
        if (PKT_MODE == 0) begin
            tvalid_c = not_empty;
        end else begin
            case (state)
                S_GATE: begin
                    tvalid_c = not_empty && ((pkts != '0) || full);
                    if (tvalid_c && bus.axis_tready && !head.last) begin
                        state_nxt = S_STREAM;
                    end
                end
                S_STREAM: begin
                    tvalid_c = not_empty;
                    if (tvalid_c && bus.axis_tready && head.last) begin
                        state_nxt = S_GATE;
                    end
                end
                default: begin
                    state_nxt = S_GATE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_master_buf.sv
// tb_axis_master_buf: checks a cut-through and a store-and-forward instance (DEPTH=4) against a beat scoreboard.
// Latency: stimulus aligned 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpressure: axis_tready driven per test; backend waits (bounded) on bk_ready.
module tb_axis_master_buf;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t in;
        beat_t exp;
    } vec_t;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [2:0]  level0, level1;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    int          tests = 0;
    int          fails = 0;
    beat_t       sb0[$];
    beat_t       sb1[$];
    logic        prev_v[2];
    logic        prev_hs[2];
    logic [31:0] prev_d[2];
    int          beats[2];
    logic [15:0] exp_pkt[2];
    logic        stream_chk = 1'b0;
    vec_t        vt[8];

    always #5 axi_aclk = ~axi_aclk;

    axis_master_buf_if #(.DATA_WIDTH(32), .USER_WIDTH(2)) if0 ();
    axis_master_buf_if #(.DATA_WIDTH(32), .USER_WIDTH(2)) if1 ();

    axis_master_buf #(.DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(4), .PKT_MODE(0)) dut0 (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .bus(if0.master),
        .level(level0), .pkt_cnt(pkt_cnt0));

    axis_master_buf #(.DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(4), .PKT_MODE(1)) dut1 (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .bus(if1.master),
        .level(level1), .pkt_cnt(pkt_cnt1));

    function automatic beat_t mk(logic [31:0] d, logic [3:0] k, logic [1:0] u, logic l);
        beat_t b;
        b.data = d; b.keep = k; b.user = u; b.last = l;
        return b;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int qsize(int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic rdy(int d);
        return (d == 0) ? if0.bk_ready : if1.bk_ready;
    endfunction

    task automatic drive(int d, logic v, beat_t b);
        if (d == 0) begin
            if0.bk_valid = v; if0.bk_data = b.data; if0.bk_keep = b.keep;
            if0.bk_user = b.user; if0.bk_last = b.last;
        end else begin
            if1.bk_valid = v; if1.bk_data = b.data; if1.bk_keep = b.keep;
            if1.bk_user = b.user; if1.bk_last = b.last;
        end
    endtask

    // Presents one beat; the expected output is queued once the write is certain.
    task automatic send(int d, beat_t b, beat_t e);
        int n = 0;
        drive(d, 1'b1, b);
        @(negedge axi_aclk);
        while (!rdy(d) && n < 100) begin
            @(negedge axi_aclk);
            n++;
        end
        if (!rdy(d)) begin
            tests++; fails++;
            $display("FAIL send_timeout dut%0d: bk_ready=0 after %0d cycles, required 1", d, n);
        end else if (d == 0) begin
            sb0.push_back(e);
        end else begin
            sb1.push_back(e);
        end
        @(posedge axi_aclk);
        #1;
        drive(d, 1'b0, b);
    endtask

    task automatic drain(int d);
        int n = 0;
        while (qsize(d) != 0 && n < 300) begin
            @(negedge axi_aclk);
            n++;
        end
        if (qsize(d) != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout dut%0d: %0d beats outstanding, required 0", d, qsize(d));
        end
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic mon(int d, logic v, logic r, logic [31:0] dat, logic [3:0] kp,
                       logic [3:0] st, logic [1:0] us, logic la);
        beat_t e;
        if (prev_v[d] && !prev_hs[d]) begin
            chk($sformatf("tvalid_hold%0d", d), {31'd0, v}, 32'd1);
            chk($sformatf("payload_hold%0d", d), dat, prev_d[d]);
        end
        if (v && r) begin
            if (qsize(d) == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_beat dut%0d: got data 0x%0h, required no beat", d, dat);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk($sformatf("tdata%0d", d), dat, e.data);
                chk($sformatf("tkeep%0d", d), {28'd0, kp}, {28'd0, e.keep});
                chk($sformatf("tstrb%0d", d), {28'd0, st}, {28'd0, e.keep});
                chk($sformatf("tuser%0d", d), {30'd0, us}, {30'd0, e.user});
                chk($sformatf("tlast%0d", d), {31'd0, la}, {31'd0, e.last});
                beats[d]++;
                if (e.last) exp_pkt[d]++;
            end
        end
        prev_v[d]  = v;
        prev_hs[d] = v && r;
        prev_d[d]  = dat;
    endtask

    initial begin
        forever begin
            @(negedge axi_aclk);
            if (!axi_aresetn) begin
                prev_v[0] = 1'b0; prev_v[1] = 1'b0;
            end else begin
                mon(0, if0.axis_tvalid, if0.axis_tready, if0.axis_tdata, if0.axis_tkeep,
                    if0.axis_tstrb, if0.axis_tuser, if0.axis_tlast);
                mon(1, if1.axis_tvalid, if1.axis_tready, if1.axis_tdata, if1.axis_tkeep,
                    if1.axis_tstrb, if1.axis_tuser, if1.axis_tlast);
                if (stream_chk) begin
                    chk("stream_level_le1", {31'd0, level0 <= 3'd1}, 32'd1);
                    chk("stream_bk_ready", {31'd0, if0.bk_ready}, 32'd1);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    n;
        prev_v[0] = 1'b0; prev_v[1] = 1'b0; prev_hs[0] = 1'b0; prev_hs[1] = 1'b0;
        prev_d[0] = '0; prev_d[1] = '0; beats[0] = 0; beats[1] = 0;
        exp_pkt[0] = '0; exp_pkt[1] = '0;
        b = mk(32'd0, 4'h0, 2'd0, 1'b0);
        drive(0, 1'b0, b);
        drive(1, 1'b0, b);
        if0.axis_tready = 1'b0;
        if1.axis_tready = 1'b0;

        // Sideband table: random keep/user pass through unchanged.
        for (int i = 0; i < 8; i++) begin
            vt[i].in  = mk($urandom, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), i == 7);
            vt[i].exp = vt[i].in;
        end

        // Reset state (asynchronous, before any clock edge)
        #1;
        chk("rst_tvalid0", {31'd0, if0.axis_tvalid}, 32'd0);
        chk("rst_bk_ready0", {31'd0, if0.bk_ready}, 32'd1);
        chk("rst_level0", {29'd0, level0}, 32'd0);
        chk("rst_pkt_cnt0", {16'd0, pkt_cnt0}, 32'd0);
        chk("rst_tvalid1", {31'd0, if1.axis_tvalid}, 32'd0);
        repeat (3) @(posedge axi_aclk);
        #3 axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;

        // Cut-through streaming, 16 back-to-back beats
        if0.axis_tready = 1'b1;
        beats[0] = 0;
        stream_chk = 1'b1;
        b = mk(32'd1, 4'hF, 2'd1, 1'b0);
        send(0, b, b);
        chk("first_beat_latency", {31'd0, if0.axis_tvalid}, 32'd1);
        for (int i = 2; i <= 16; i++) begin
            b = mk(i, 4'hF, 2'(i), i == 16);
            send(0, b, b);
        end
        stream_chk = 1'b0;
        drain(0);
        chk("stream_beats", beats[0], 32'd16);
        chk("stream_pkt_cnt", {16'd0, pkt_cnt0}, 32'd1);

        // Fill, backpressure and wrap
        if0.axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b = mk(i, 4'hF, 2'd0, 1'b0);
            send(0, b, b);
        end
        chk("full_level", {29'd0, level0}, 32'd4);
        chk("full_bk_ready", {31'd0, if0.bk_ready}, 32'd0);
        chk("full_tvalid", {31'd0, if0.axis_tvalid}, 32'd1);
        chk("full_head", if0.axis_tdata, 32'd1);
        fork
            begin
                b = mk(32'd5, 4'hF, 2'd0, 1'b1);
                send(0, b, b);
            end
            begin
                repeat (3) begin
                    @(negedge axi_aclk);
                    chk("held_tvalid", {31'd0, if0.axis_tvalid}, 32'd1);
                    chk("held_tdata", if0.axis_tdata, 32'd1);
                    chk("held_bk_ready", {31'd0, if0.bk_ready}, 32'd0);
                end
                @(posedge axi_aclk);
                #1 if0.axis_tready = 1'b1;
            end
        join
        drain(0);
        chk("drained_level", {29'd0, level0}, 32'd0);
        chk("drained_bk_ready", {31'd0, if0.bk_ready}, 32'd1);

        // Sideband propagation from the vector table
        for (int i = 0; i < 8; i++) begin
            send(0, vt[i].in, vt[i].exp);
        end
        drain(0);

        // Store-and-forward: 3-beat packet with gaps
        if1.axis_tready = 1'b1;
        b = mk(32'hA1, 4'h1, 2'd1, 1'b0);
        send(1, b, b);
        repeat (2) begin
            @(negedge axi_aclk);
            chk("snf_gated_a", {31'd0, if1.axis_tvalid}, 32'd0);
        end
        @(posedge axi_aclk); #1;
        b = mk(32'hA2, 4'h3, 2'd2, 1'b0);
        send(1, b, b);
        @(negedge axi_aclk);
        chk("snf_gated_b", {31'd0, if1.axis_tvalid}, 32'd0);
        @(posedge axi_aclk); #1;
        b = mk(32'hA3, 4'h7, 2'd3, 1'b1);
        send(1, b, b);
        chk("snf_release", {31'd0, if1.axis_tvalid}, 32'd1);
        drain(1);
        chk("snf_pkt_cnt", {16'd0, pkt_cnt1}, 32'd1);

        // Oversize packet: 6 beats through a 4-entry FIFO
        for (int i = 1; i <= 3; i++) begin
            b = mk(32'hB0 + i, 4'hF, 2'd0, 1'b0);
            send(1, b, b);
            chk("big_gated", {31'd0, if1.axis_tvalid}, 32'd0);
        end
        b = mk(32'hB4, 4'hF, 2'd0, 1'b0);
        send(1, b, b);
        chk("big_full_level", {29'd0, level1}, 32'd4);
        chk("big_full_release", {31'd0, if1.axis_tvalid}, 32'd1);
        b = mk(32'hB5, 4'hF, 2'd0, 1'b0);
        send(1, b, b);
        b = mk(32'hB6, 4'hF, 2'd0, 1'b1);
        send(1, b, b);
        drain(1);
        chk("big_pkt_cnt", {16'd0, pkt_cnt1}, 32'd2);
        chk("big_level", {29'd0, level1}, 32'd0);
        // Back in the gated state: a lone non-last beat must stay held.
        b = mk(32'hC1, 4'hF, 2'd1, 1'b0);
        send(1, b, b);
        repeat (3) begin
            @(negedge axi_aclk);
            chk("regated", {31'd0, if1.axis_tvalid}, 32'd0);
        end
        @(posedge axi_aclk); #1;
        b = mk(32'hC2, 4'hF, 2'd2, 1'b1);
        send(1, b, b);
        drain(1);
        chk("regated_pkt_cnt", {16'd0, pkt_cnt1}, 32'd3);

        // pkt_cnt wrap: bring the counter to 0xFFFF with single-beat packets, then one more.
        n = 65535 - int'(exp_pkt[0]);
        for (int i = 0; i < n; i++) begin
            b = mk(i, 4'hF, 2'(i), 1'b1);
            send(0, b, b);
        end
        drain(0);
        chk("pkt_cnt_max", {16'd0, pkt_cnt0}, 32'h0000FFFF);
        b = mk(32'h5A5A5A5A, 4'hF, 2'd3, 1'b1);
        send(0, b, b);
        drain(0);
        chk("pkt_cnt_wrap", {16'd0, pkt_cnt0}, 32'd0);

        // Reset mid-packet with three beats buffered
        if0.axis_tready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            b = mk(32'hD0 + i, 4'hF, 2'd0, 1'b0);
            send(0, b, b);
        end
        chk("pre_rst_level", {29'd0, level0}, 32'd3);
        #2 axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'd0, if0.axis_tvalid}, 32'd0);
        chk("mid_rst_bk_ready", {31'd0, if0.bk_ready}, 32'd1);
        chk("mid_rst_level", {29'd0, level0}, 32'd0);
        chk("mid_rst_pkt_cnt", {16'd0, pkt_cnt0}, 32'd0);
        sb0.delete();
        exp_pkt[0] = '0;
        repeat (2) @(negedge axi_aclk);
        @(posedge axi_aclk);
        #3 axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        chk("post_rst_no_beat", {31'd0, if0.axis_tvalid}, 32'd0);
        @(posedge axi_aclk);
        #1 if0.axis_tready = 1'b1;
        b = mk(32'hCAFEF00D, 4'h9, 2'd2, 1'b1);
        send(0, b, b);
        drain(0);
        chk("post_rst_pkt_cnt", {16'd0, pkt_cnt0}, 32'd1);
        chk("post_rst_level", {29'd0, level0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
